// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default count width, count ceiling and direction encoding.
// Used by the timebase here and by the downstream comparator.
package pwm_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Programmable prescaler: one tick every presc_i+1 enabled cycles.
// The tick is combinational so the counter advances on the same edge the interval ends.
module pwm_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] r_prescCnt;
  logic               w_tick;

  // >= so that lowering presc_i mid-interval ends the interval on the next cycle
  assign w_tick = en_i && (r_prescCnt >= presc_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prescCnt <= '0;
    end else if (en_i) begin
      if (w_tick) begin
        r_prescCnt <= '0;
      end else begin
        r_prescCnt <= r_prescCnt + 1'b1;
      end
    end
  end

  assign tick_o = w_tick;

endmodule

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaled 2^CNT_W count plus double-buffered duty reference.
// Define PWM_CENTER_ALIGNED_EN for a triangular (up/down) count instead of a sawtooth.
module pwm_timebase #(
  parameter int CNT_W   = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic [CNT_W-1:0]   duty_i,
  input  logic               duty_wr_i,
  output logic [CNT_W-1:0]   cont_o,
  output logic [CNT_W-1:0]   ref_o,
  output logic               period_end_o,
  output logic               upd_pending_o
);

  import pwm_pkg::*;

  localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};

  logic             w_tick;
  logic             w_wrap;
  logic [CNT_W-1:0] w_contNext;
  logic [CNT_W-1:0] r_cont;
  logic [CNT_W-1:0] r_ref;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pending;
  logic             r_periodEnd;

  pwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .presc_i (presc_i),
    .tick_o  (w_tick)
  );

`ifdef PWM_CENTER_ALIGNED_EN
  dir_e r_dir;
  dir_e w_dirNext;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dir <= DIR_UP;
    end else begin
      r_dir <= w_dirNext;
    end
  end

  always_comb begin
    w_dirNext = r_dir;
    if (w_tick) begin
      if ((r_dir == DIR_UP) && (r_cont == L_CNT_MAX)) begin
        w_dirNext = DIR_DOWN;
      end else if ((r_dir == DIR_DOWN) && (r_cont == '0)) begin
        w_dirNext = DIR_UP;
      end
    end
  end

  // The period boundary is the DOWN->UP turn at zero
  always_comb begin
    w_contNext = r_cont;
    w_wrap     = 1'b0;
    if (w_tick) begin
      if (w_dirNext == DIR_UP) begin
        w_contNext = r_cont + 1'b1;
      end else begin
        w_contNext = r_cont - 1'b1;
      end
      w_wrap = (r_dir == DIR_DOWN) && (r_cont == '0);
    end
  end
`else
  always_comb begin
    w_contNext = r_cont;
    w_wrap     = 1'b0;
    if (w_tick) begin
      w_contNext = r_cont + 1'b1;
      w_wrap     = (r_cont == L_CNT_MAX);
    end
  end
`endif

  // A write on the wrap edge still lets the previously pending value reach ref
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cont      <= '0;
      r_ref       <= '0;
      r_shadow    <= '0;
      r_pending   <= 1'b0;
      r_periodEnd <= 1'b0;
    end else begin
      r_cont      <= w_contNext;
      r_periodEnd <= w_wrap;
      if (w_wrap && r_pending) begin
        r_ref <= r_shadow;
      end
      if (duty_wr_i) begin
        r_shadow  <= duty_i;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign cont_o        = r_cont;
  assign ref_o         = r_ref;
  assign period_end_o  = r_periodEnd;
  assign upd_pending_o = r_pending;

endmodule

// File: doc/pwm_timebase.md
Name: pwm_timebase

Overview:
Upstream stage of the PWM comparator. Generates the free-running 4-bit sawtooth count (cont_o) and the double-buffered duty reference (ref_o), which drive the comparator's cont_i and ref inputs directly. A programmable prescaler sets the count rate. Duty updates are applied only at the period boundary, so the modulated output never glitches.

Parameters:
CNT_W, 4, width of the count and duty reference; period = 2^CNT_W ticks.
PRESC_W, 8, width of the prescaler divide register.

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
en_i  input  1  count enable; low freezes the timebase
presc_i  input  PRESC_W  divide value; one tick every presc_i+1 enabled cycles
duty_i  input  CNT_W  new duty value
duty_wr_i  input  1  one-cycle strobe; captures duty_i into the shadow register
cont_o  output  CNT_W  current count, to comparator cont_i
ref_o  output  CNT_W  active duty reference, to comparator ref
period_end_o  output  1  one-cycle pulse on the tick that wraps cont_o to 0
upd_pending_o  output  1  shadow holds a value not yet applied to ref_o

Behaviour:
- Reset (rst_i=1 at a clock edge): presc_cnt=0, cont_o=0, ref_o=0, shadow=0, upd_pending_o=0, period_end_o=0, direction=UP. Reset has priority over every other input. A reset mid-period discards any pending update.
- Prescaler: while en_i=1, tick=1 when presc_cnt >= presc_i, and presc_cnt then returns to 0. Otherwise presc_cnt increments. The >= comparison makes a mid-count reduction of presc_i end the current interval on the next cycle. presc_i=0 gives a tick every cycle.
- Counter (sawtooth): on each tick, cont_o increments modulo 2^CNT_W (15 -> 0 for CNT_W=4).
- Wrap event: a tick with cont_o = 2^CNT_W-1 is a wrap. On that same edge:
  - cont_o goes to 0.
  - period_end_o=1 for exactly one cycle.
  - If upd_pending_o=1, ref_o loads shadow and upd_pending_o clears.
- Shadow write: duty_wr_i=1 loads shadow=duty_i and sets upd_pending_o=1 on the next edge. Writes are accepted regardless of en_i.
- Write and wrap on the same edge: ref_o takes the old shadow value if one was pending (otherwise it is unchanged). shadow takes duty_i and upd_pending_o=1. The new value applies at the following wrap.
- Back-to-back writes: the last one wins.
- en_i=0: presc_cnt, cont_o and ref_o hold; period_end_o=0.
- Latency: the first tick after reset occurs presc_i+1 enabled cycles after en_i rises. A write becomes visible on ref_o at the first wrap strictly after the write edge.
- Outputs are registered; there are no combinational paths from input to output.

Optional Feature:
Macro PWM_CENTER_ALIGNED_EN.
- Defined: a two-state direction FSM (UP, DOWN) makes the count triangular.
  - UP: on tick, count+1; at 2^CNT_W-1 the next tick goes to DOWN with count-1.
  - DOWN: on tick, count-1; at 0 the next tick goes to UP with count+1.
  - The wrap event (period_end_o pulse, shadow apply) is the DOWN->UP turn at 0.
  - Period = 2*(2^CNT_W-1) ticks.
- Undefined: sawtooth only; no direction register is synthesized.

Decomposition:
- Shared package pwm_pkg holds:
  - the CNT_W default (4), shared with the comparator;
  - the direction encoding (UP=1'b0, DOWN=1'b1);
  - the CNT_MAX constant.
- One natural sub-module, pwm_prescaler (presc_cnt plus tick generation). The counter, shadow register and FSM stay in the top module.

Test Plan:
- Reset, then en_i=1, presc_i=0 -> cont_o runs 0,1,…,15,0 one step per cycle; period_end_o pulses exactly once per 16 cycles, on the cycle cont_o becomes 0.
- presc_i=3 -> cont_o advances every 4 cycles; presc_i changed 3->1 while presc_cnt=2 -> tick on the next cycle, then every 2 cycles.
- duty_wr_i with duty_i=9 while cont_o=5 -> upd_pending_o=1 and ref_o stays 0 until the wrap; ref_o=9 on the 15->0 edge and upd_pending_o clears.
- duty_wr_i with duty_i=7 on the wrap edge while shadow=9 is pending -> ref_o=9, upd_pending_o stays 1; ref_o=7 at the next wrap.
- en_i low for 10 cycles at cont_o=6 -> cont_o holds 6, period_end_o=0; a write during the hold is still captured. rst_i mid-period with an update pending -> all outputs 0 on the next edge.
- With PWM_CENTER_ALIGNED_EN defined, presc_i=0 -> sequence 0..15..0 over 30 ticks; period_end_o and the shadow apply occur only at the DOWN->UP turn at 0.
